// File: rtl/dtlb_ubuf_if.sv
// Refill port between the data micro-TLB and the main TLB search port.
// The micro-TLB holds req level-high until the one-cycle ack returns the result.
interface dtlb_ubuf_if #(
    parameter int ASID_W = 8,
    parameter int PFN_W  = 20
);
    logic              req;
    logic [18:0]       vpn2;
    logic              ack;
    logic              found;
    logic [ASID_W-1:0] asid;
    logic              g;
    logic [PFN_W+4:0]  lo0;
    logic [PFN_W+4:0]  lo1;

    modport master (output req, vpn2, input ack, found, asid, g, lo0, lo1);
    modport slave  (input req, vpn2, output ack, found, asid, g, lo0, lo1);
endinterface

// File: rtl/dtlb_ubuf.sv
// Multi-entry data micro-TLB for the MEM stage: zero-latency lookup, unmapped
// kseg0/kseg1 pass-through, and a single outstanding refill from the main TLB.
//
// state | meaning
// IDLE  | lookups served from the buffer; a mapped miss launches a refill
// REQ   | refill requested, waiting for the main TLB ack
// DRAIN | a flush hit the in-flight refill; wait for ack and drop the result
module dtlb_ubuf #(
    parameter int ENTRIES = 4,
    parameter int ASID_W  = 8,
    parameter int PFN_W   = 20
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    input  logic [19:0]       req_vaddr,
    input  logic              req_is_store,
    input  logic              flush,
    input  logic [ASID_W-1:0] cur_asid,
    input  logic [2:0]        cp0_k0,
    dtlb_ubuf_if.master       tlb,
    output logic [PFN_W-1:0]  paddr_tag,
    output logic              is_cached,
    output logic              xlat_valid,
    output logic              stall,
    output logic [2:0]        exc_type
);
    localparam int IDX_W = $clog2(ENTRIES);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t state_q, state_d;

    logic [ENTRIES-1:0] ent_valid;
    logic [18:0]        ent_vpn2 [ENTRIES];
    logic [ASID_W-1:0]  ent_asid [ENTRIES];
    logic               ent_g    [ENTRIES];
    logic [PFN_W+4:0]   ent_lo0  [ENTRIES];
    logic [PFN_W+4:0]   ent_lo1  [ENTRIES];

    logic [IDX_W-1:0]   rr_ptr;
    logic [18:0]        pend_vpn2;
    logic [ASID_W-1:0]  pend_asid;
    logic               neg_valid;
    logic [18:0]        neg_vpn2;
    logic [ASID_W-1:0]  neg_asid;

    logic               mapped;
    logic               hit;
    logic [IDX_W-1:0]   hit_idx;
    logic               neg_hit;
    logic [PFN_W+4:0]   sel_lo;
    logic               has_free;
    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   victim;
    logic               miss;
    logic               fill_we;
    logic               neg_set;

    assign mapped = (req_vaddr[19:18] != 2'b10);

    // Descending scan so the lowest matching / free index is the one kept.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        has_free = 1'b0;
        free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (ent_valid[i] && (ent_vpn2[i] == req_vaddr[19:1]) &&
                (ent_g[i] || (ent_asid[i] == cur_asid))) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!ent_valid[i]) begin
                has_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    assign sel_lo  = req_vaddr[0] ? ent_lo1[hit_idx] : ent_lo0[hit_idx];
    assign victim  = has_free ? free_idx : rr_ptr;
    assign neg_hit = neg_valid && (neg_vpn2 == req_vaddr[19:1]) && (neg_asid == cur_asid);
    assign miss    = req_valid && mapped && !hit && !neg_hit;
    assign fill_we = (state_q == REQ) && tlb.ack && tlb.found && !flush;
    assign neg_set = (state_q == REQ) && tlb.ack && !tlb.found && !flush;

    always_comb begin
        state_d = state_q;
        tlb.req = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (miss) state_d = REQ;
            end
            REQ: begin
                tlb.req = 1'b1;
                if (tlb.ack)    state_d = IDLE;
                else if (flush) state_d = DRAIN;
            end
            DRAIN: begin
                tlb.req = 1'b1;
                if (tlb.ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        paddr_tag  = '0;
        is_cached  = 1'b0;
        xlat_valid = 1'b0;
        stall      = 1'b0;
        exc_type   = 3'b000;
        if (req_valid) begin
            if (!mapped) begin
                paddr_tag  = PFN_W'(req_vaddr[16:0]);
                is_cached  = !req_vaddr[17] && (cp0_k0 == 3'd3);
                xlat_valid = 1'b1;
            end else if (state_q != IDLE) begin
                stall = 1'b1;
            end else if (hit) begin
                if (!sel_lo[0]) begin
                    exc_type = req_is_store ? 3'b101 : 3'b010;
                end else if (req_is_store && !sel_lo[1]) begin
                    exc_type = 3'b011;
                end else begin
                    paddr_tag  = sel_lo[PFN_W+4:5];
                    is_cached  = (sel_lo[4:2] == 3'd3);
                    xlat_valid = 1'b1;
                end
            end else if (neg_hit) begin
                exc_type = req_is_store ? 3'b100 : 3'b001;
            end else begin
                stall = 1'b1;
            end
        end
    end

    assign tlb.vpn2 = pend_vpn2;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            ent_valid <= '0;
            rr_ptr    <= '0;
            neg_valid <= 1'b0;
            neg_vpn2  <= '0;
            neg_asid  <= '0;
            pend_vpn2 <= '0;
            pend_asid <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && miss) begin
                pend_vpn2 <= req_vaddr[19:1];
                pend_asid <= cur_asid;
            end
            if (flush) begin
                ent_valid <= '0;
                neg_valid <= 1'b0;
            end else if (fill_we) begin
                ent_valid[victim] <= 1'b1;
                neg_valid         <= 1'b0;
                if (!has_free) rr_ptr <= rr_ptr + IDX_W'(1);
            end else if (neg_set) begin
                neg_valid <= 1'b1;
                neg_vpn2  <= pend_vpn2;
                neg_asid  <= pend_asid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we) begin
            ent_vpn2[victim] <= pend_vpn2;
            ent_asid[victim] <= tlb.asid;
            ent_g[victim]    <= tlb.g;
            ent_lo0[victim]  <= tlb.lo0;
            ent_lo1[victim]  <= tlb.lo1;
        end
    end
endmodule

// File: doc/dtlb_ubuf.md
Name: dtlb_ubuf

Overview:
- Multi-entry data micro-TLB in the MEM stage. Successor to the single-entry DTLB buffer; entry count is parametrised.
- Translates MEM_ALUOut[31:12] to a physical tag for the Dcache and produces the TLB exception code.
- On a miss, stalls the pipe and refills one entry from the main TLB's search port through a req/ack handshake.
- Handles unmapped kseg0/kseg1 directly, supports G/ASID matching, and preserves flush correctness across an in-flight refill.

Parameters:
- ENTRIES, 4, number of buffer entries (power of two, 2..16).
- ASID_W, 8, ASID width.
- PFN_W, 20, physical frame number width.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- req_valid  in  1  MEM stage holds a load/store this cycle
- req_vaddr  in  20  virtual address [31:12]
- req_is_store  in  1  access is a store
- flush  in  1  invalidate all entries (TLBWI/TLBWR/TLBR or EntryHi write; already gated by DisWr)
- cur_asid  in  ASID_W  CP0 EntryHi.ASID
- cp0_k0  in  3  CP0 Config.K0
- tlb_req  out  1  refill request to the main TLB
- tlb_vpn2  out  19  VPN2 being refilled
- tlb_ack  in  1  main TLB result valid, one cycle
- tlb_found  in  1  main TLB hit
- tlb_asid  in  ASID_W  matched entry ASID
- tlb_g  in  1  matched entry G
- tlb_lo0  in  PFN_W+5  {PFN, C[2:0], D, V} for the even page
- tlb_lo1  in  PFN_W+5  {PFN, C[2:0], D, V} for the odd page
- paddr_tag  out  PFN_W  physical address [31:12]
- is_cached  out  1  access is cacheable
- xlat_valid  out  1  translation usable this cycle (valid-qualifier for the Dcache request)
- stall  out  1  D_IsTLBStall equivalent
- exc_type  out  3  000 none, 001 refill-load, 010 invalid-load, 011 modify, 100 refill-store, 101 invalid-store

Behaviour:
- Reset:
  - all entry valid bits 0; round-robin pointer 0; negative record invalid; FSM IDLE.
  - tlb_req 0; stall, xlat_valid and exc_type 0 while req_valid=0.
- req_valid=0: stall=0, xlat_valid=0, exc_type=000; no refill is started.
- Unmapped segments (combinational, no stall):
  - vaddr[31:30]=2'b10: paddr_tag = {3'b000, vaddr[28:12]}, xlat_valid=1.
  - is_cached = (cp0_k0==3'd3) for kseg0 (vaddr[29]=0); is_cached = 0 for kseg1.
- Mapped lookup (combinational, 0 latency):
  - Entry hits when valid, vpn2 == vaddr[31:13], and (g or asid == cur_asid).
  - vaddr[12] selects lo0/lo1.
  - Hit with V=0: exc 010/101, xlat_valid=0.
  - Hit with store and D=0: exc 011, xlat_valid=0.
  - Otherwise: paddr_tag = PFN, is_cached = (C==3), xlat_valid=1.
  - More than one hit cannot occur; lowest index wins.
- Miss: stall=1 and xlat_valid=0 in the same cycle.
- FSM:
  - IDLE→REQ on a mapped miss; tlb_vpn2 is latched.
  - REQ: tlb_req=1 and stall=1 until tlb_ack.
  - On ack with found=1: write the entry into the victim slot (lowest invalid entry, else the round-robin pointer, which then increments mod ENTRIES). → IDLE.
  - On ack with found=0: set the negative record {vpn2, asid} valid. → IDLE.
  - Earliest hit is the cycle after ack. Minimum miss penalty with a 1-cycle TLB is 2 stall cycles.
- Negative record: a matching lookup returns exc 001/100, stall=0, xlat_valid=0. Cleared by flush or any successful refill.
- Flush:
  - Clears all valid bits and the negative record at the clock edge. A lookup in the flush cycle uses pre-flush contents.
  - Flush in REQ: go to DRAIN. DRAIN keeps stall=1 (if req_valid) and waits for tlb_ack, then discards the result → IDLE. The next cycle re-misses.
  - Flush coincident with tlb_ack: flush wins, nothing is written.
- req_valid dropping or req_vaddr changing during REQ: the refill completes and is written normally.
- Async reset mid-refill: FSM returns to IDLE immediately; a later stray tlb_ack is ignored in IDLE.

Test Plan:
- Reset, req kseg0 vaddr 0x80001 with k0=3 → paddr_tag 0x00001, is_cached=1, stall=0. Same with k0=2 → is_cached=0. kseg1 0xA0002 → paddr_tag 0x00002, is_cached=0.
- Mapped load 0x00400, empty buffer → stall 1 at cycle 0; tlb_req at cycle 1 with tlb_vpn2=0x00200; ack found (lo0 PFN 0x12345, C=3, V=1) at cycle 1 → cycle 2 paddr_tag 0x12345, is_cached=1, stall=0.
- Store to a hit entry with D=0 → exc 011, xlat_valid=0. Load to a page with V=0 → exc 010. Ack with found=0 → next cycle load gives exc 001, store gives exc 100.
- Fill ENTRIES+1 distinct VPN2s → the 5th fill (ENTRIES=4) replaces entry 0. Re-access of the 1st VPN2 misses; the 2nd still hits.
- Flush asserted during REQ, ack two cycles later → no write, stall held through ack. Next cycle misses again and a new tlb_req is issued.
- G=0 entry with ASID 0x05, cur_asid changed to 0x06 → miss. G=1 entry → hit regardless of ASID.
